multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multi-cycle CPU. It sequences every instruction through fetch, decode, execute, memory and writeback. It generates the state code, next-state logic and all datapath control strobes each cycle. It supports a pause stall and a memory wait handshake.

## Interface
Parameters:
- RST_STATE, 4'd15: state code loaded on reset (IDLE).

Ports:
- multi_clk  in  1  CPU multi-cycle clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pause  in  1  stall; state held, write strobes forced 0.
- opcode  in  6  IR[31:26].
- zero  in  1  ALU zero flag, valid in BRANCH.
- mem_ready  in  1  memory completed current access this cycle.
- current_state  out  4  present state code.
- pc_write, ir_write, reg_write, mem_write  out  1 each  write strobes.
- mem_read  out  1  memory read request.
- i_or_d  out  1  0 = PC address, 1 = ALUOut address.
- reg_dst, mem_to_reg, alu_src_a  out  1 each  datapath muxes.
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- alu_op  out  2  00 add, 01 sub, 10 funct, 11 immediate-op.
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  one-cycle pulse in ID on unknown opcode.

## Operation
- State codes: IF=0, ID=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXE_R=6, WB_R=7, BRANCH=8, JUMP=9, EXE_I=10, WB_I=11, IDLE=15. Codes 12–14 are unused and go to IF on the next edge.
- IDLE → IF unconditionally.
- IF:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write assert only when mem_ready=1, then → ID. Otherwise stay in IF.
- ID: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target to ALUOut). Dispatch on opcode:
  - 0x23 or 0x2B → MEM_ADDR.
  - 0x00 → EXE_R.
  - 0x04 or 0x05 → BRANCH.
  - 0x02 → JUMP.
  - 0x08, 0x0A, 0x0C or 0x0D → EXE_I.
  - Any other opcode → IF with illegal_op=1.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. lw → MEM_RD; sw → MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. → MEM_WB on mem_ready, else hold.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1. → IF.
- MEM_WR: mem_write=1, i_or_d=1. → IF on mem_ready (instr_done=1 that cycle), else hold.
- EXE_R: alu_src_a=1, alu_src_b=00, alu_op=10. → WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. → IF.
- EXE_I: alu_src_a=1, alu_src_b=10, alu_op=11. → WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. → IF.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, instr_done=1. → IF.
  - pc_write = zero for beq, ~zero for bne (opcode held in IR).
- JUMP: pc_source=10, pc_write=1, instr_done=1. → IF.
- Unlisted outputs are 0 in every state.

## Timing
- Reset: asynchronous. current_state=15 immediately. All strobes and pulses 0 while rst_n=0. First IF occurs one edge after release.
- Outputs are Moore, decoded from current_state. Exceptions are the mem_ready-qualified strobes in IF and MEM_WR, and zero in BRANCH.
- Latency with mem_ready=1, counted from IF through retirement: lw 5, sw 4, R 4, I 4, branch 3, jump 3 cycles.
- pause=1: state holds across edges. pc_write, ir_write, reg_write, mem_write, instr_done and illegal_op are forced 0. mem_read and the mux selects keep their state values.
- pause has priority over mem_ready. A ready arriving during pause is ignored, and memory must re-present ready.
- Reset asserted mid-instruction abandons the instruction; no strobe fires after rst_n falls.

## Structure
- Shared package ctrl_pkg holds:
  - the state code constants;
  - opcode constants (LW, SW, RTYPE, BEQ, BNE, J, ADDI, SLTI, ANDI, ORI);
  - alu_op, alu_src_b and pc_source encodings.
- One sub-module, mc_opcode_decode, is combinational. It maps opcode to the dispatch class: mem, rtype, branch, jump, imm or illegal.
- The top level holds the state register and output decode.

## Test plan
- Reset/boot: rst_n low 3 cycles, then high → current_state 15, then 0 on the next edge; all strobes 0 during reset.
- lw, mem_ready=1: states 0,1,2,3,4,0. MEM_WB has reg_write=1 and mem_to_reg=1. instr_done pulses exactly once.
- sw, mem_ready low for 2 cycles in MEM_WR: state stays 5 for 3 cycles. mem_write=1 throughout, then → 0 with instr_done=1.
- beq with zero=1 → pc_write=1 in state 8. bne with zero=1 → pc_write=0. j → state 9 with pc_source=10.
- opcode 0x3F in ID → illegal_op=1, next state 0. Forcing state 13 → next state 0.
- pause=1 for 4 cycles in EXE_R → state stays 6 with no write strobes. rst_n dropped in WB_R → state 15 immediately and reg_write=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle CPU control unit:
// state codes, opcodes, datapath select encodings, dispatch classes.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_IF       = 4'd0,
      S_ID       = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXE_R    = 4'd6,
      S_WB_R     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_EXE_I    = 4'd10,
      S_WB_I     = 4'd11,
      S_IDLE     = 4'd15
   } state_e;

   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_IMM   = 2'b11;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;

   typedef enum logic [2:0] {
      CLS_MEM,
      CLS_RTYPE,
      CLS_BRANCH,
      CLS_JUMP,
      CLS_IMM,
      CLS_ILLEGAL
   } op_class_e;

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational opcode classifier used for ID-stage dispatch.
// in: opcode[5:0]  out: op_class (mem/rtype/branch/jump/imm/illegal)
module mc_opcode_decode
   import ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   output op_class_e  op_class
);

   always_comb begin
      op_class = CLS_ILLEGAL;
      unique case (opcode)
         OP_LW, OP_SW:                      op_class = CLS_MEM;
         OP_RTYPE:                          op_class = CLS_RTYPE;
         OP_BEQ, OP_BNE:                    op_class = CLS_BRANCH;
         OP_J:                              op_class = CLS_JUMP;
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: op_class = CLS_IMM;
         default:                           op_class = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle CPU: state register plus
// Moore output decode, with pause stall and memory-ready handshake.
// in: multi_clk, rst_n, pause, opcode, zero, mem_ready
// out: current_state, write strobes, mux selects, alu_op, pulses
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter logic [3:0] RST_STATE = 4'd15
) (
   input  logic       multi_clk,
   input  logic       rst_n,
   input  logic       pause,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [3:0] current_state,
   output logic       pc_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic       mem_write,
   output logic       mem_read,
   output logic       i_or_d,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       instr_done,
   output logic       illegal_op
);

   logic [3:0] state_q, state_d;
   op_class_e  op_class;

   mc_opcode_decode u_dec (
      .opcode   (opcode),
      .op_class (op_class)
   );

   assign current_state = state_q;

   always_comb begin
      state_d = state_q;
      if (!pause) begin
         case (state_q)
            S_IDLE:     state_d = S_IF;
            S_IF:       if (mem_ready) state_d = S_ID;
            S_ID: begin
               unique case (op_class)
                  CLS_MEM:    state_d = S_MEM_ADDR;
                  CLS_RTYPE:  state_d = S_EXE_R;
                  CLS_BRANCH: state_d = S_BRANCH;
                  CLS_JUMP:   state_d = S_JUMP;
                  CLS_IMM:    state_d = S_EXE_I;
                  default:    state_d = S_IF;
               endcase
            end
            // IR still holds the opcode, so lw/sw split here
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_IF;
            S_MEM_WR:   if (mem_ready) state_d = S_IF;
            S_EXE_R:    state_d = S_WB_R;
            S_WB_R:     state_d = S_IF;
            S_EXE_I:    state_d = S_WB_I;
            S_WB_I:     state_d = S_IF;
            S_BRANCH:   state_d = S_IF;
            S_JUMP:     state_d = S_IF;
            default:    state_d = S_IF;
         endcase
      end
   end

   always_ff @(posedge multi_clk or negedge rst_n) begin
      if (!rst_n) state_q <= RST_STATE;
      else        state_q <= state_d;
   end

   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      mem_read   = 1'b0;
      i_or_d     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      alu_op     = ALU_ADD;
      pc_source  = PCS_ALU;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      case (state_q)
         S_IF: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            pc_write  = mem_ready;
            ir_write  = mem_ready;
         end
         S_ID: begin
            alu_src_b  = SRCB_IMM_SH;
            illegal_op = (op_class == CLS_ILLEGAL);
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
         end
         S_MEM_WR: begin
            mem_write  = 1'b1;
            i_or_d     = 1'b1;
            instr_done = mem_ready;
         end
         S_EXE_R: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
         end
         S_WB_R: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
         end
         S_EXE_I: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_IMM;
         end
         S_WB_I: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a  = 1'b1;
            alu_op     = ALU_SUB;
            pc_source  = PCS_ALUOUT;
            instr_done = 1'b1;
            pc_write   = (opcode == OP_BNE) ? ~zero : zero;
         end
         S_JUMP: begin
            pc_source  = PCS_JUMP;
            pc_write   = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase
      // a stall suppresses every side effect but keeps mux selects
      if (pause) begin
         pc_write   = 1'b0;
         ir_write   = 1'b0;
         reg_write  = 1'b0;
         mem_write  = 1'b0;
         instr_done = 1'b0;
         illegal_op = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus
// random stimulus against a path-based reference model.
module tb_multicycle_ctrl;

   logic       multi_clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       pause = 1'b0;
   logic [5:0] opcode = 6'h00;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;

   logic [3:0] current_state;
   logic pc_write, ir_write, reg_write, mem_write, mem_read, i_or_d;
   logic reg_dst, mem_to_reg, alu_src_a, instr_done, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_source;

   logic [3:0] st13;
   logic pcw13, irw13, rw13, mw13, mr13, iod13;
   logic rd13, mtr13, asa13, done13, ill13;
   logic [1:0] bsel13, aop13, pcs13;

   int n_tests = 0;
   int n_fail = 0;
   int exp_state = 15;
   int q[$];
   logic obs_done, obs_ill;

   logic [16:0] got_vec, got13;

   assign got_vec = {pc_write, ir_write, reg_write, mem_write, mem_read,
                     i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                     alu_op, pc_source, instr_done, illegal_op};
   assign got13 = {pcw13, irw13, rw13, mw13, mr13, iod13, rd13, mtr13,
                   asa13, bsel13, aop13, pcs13, done13, ill13};

   always #5 multi_clk = ~multi_clk;

   multicycle_ctrl dut (
      .multi_clk(multi_clk), .rst_n(rst_n), .pause(pause),
      .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .current_state(current_state),
      .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
      .mem_write(mem_write), .mem_read(mem_read), .i_or_d(i_or_d),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
      .instr_done(instr_done), .illegal_op(illegal_op)
   );

   multicycle_ctrl #(.RST_STATE(4'd13)) dut13 (
      .multi_clk(multi_clk), .rst_n(rst_n), .pause(pause),
      .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .current_state(st13),
      .pc_write(pcw13), .ir_write(irw13), .reg_write(rw13),
      .mem_write(mw13), .mem_read(mr13), .i_or_d(iod13),
      .reg_dst(rd13), .mem_to_reg(mtr13), .alu_src_a(asa13),
      .alu_src_b(bsel13), .alu_op(aop13), .pc_source(pcs13),
      .instr_done(done13), .illegal_op(ill13)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit legal(input logic [5:0] op);
      case (op)
         6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h02,
         6'h08, 6'h0A, 6'h0C, 6'h0D: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Expected control word for a state given the live inputs
   function automatic logic [16:0] exp_out(input int st,
         input logic [5:0] op, input logic z, input logic rdy,
         input logic pse);
      logic pcw, irw, rw, mw, mr, iod, rd, mtr, asa, done, ill;
      logic [1:0] bsel, aop, pcs;
      {pcw, irw, rw, mw, mr, iod, rd, mtr, asa, done, ill} = '0;
      bsel = 0; aop = 0; pcs = 0;
      case (st)
         0:  begin mr = 1; bsel = 1; pcw = rdy; irw = rdy; end
         1:  begin bsel = 3; ill = !legal(op); end
         2:  begin asa = 1; bsel = 2; end
         3:  begin mr = 1; iod = 1; end
         4:  begin rw = 1; mtr = 1; done = 1; end
         5:  begin mw = 1; iod = 1; done = rdy; end
         6:  begin asa = 1; aop = 2; end
         7:  begin rw = 1; rd = 1; done = 1; end
         8:  begin
            asa = 1; aop = 1; pcs = 1; done = 1;
            pcw = (op == 6'h04) ? z : !z;
         end
         9:  begin pcs = 2; pcw = 1; done = 1; end
         10: begin asa = 1; bsel = 2; aop = 3; end
         11: begin rw = 1; done = 1; end
         default: ;
      endcase
      if (pse) {pcw, irw, rw, mw, done, ill} = '0;
      return {pcw, irw, rw, mw, mr, iod, rd, mtr, asa, bsel, aop, pcs,
              done, ill};
   endfunction

   // States an instruction visits after ID
   task automatic build_path(input logic [5:0] op);
      q.delete();
      case (op)
         6'h23: begin q.push_back(2); q.push_back(3); q.push_back(4); end
         6'h2B: begin q.push_back(2); q.push_back(5); end
         6'h00: begin q.push_back(6); q.push_back(7); end
         6'h04, 6'h05: q.push_back(8);
         6'h02: q.push_back(9);
         6'h08, 6'h0A, 6'h0C, 6'h0D: begin
            q.push_back(10); q.push_back(11);
         end
         default: ;
      endcase
   endtask

   task automatic advance();
      if (q.size() == 0) exp_state = 0;
      else exp_state = q.pop_front();
   endtask

   task automatic step_model();
      if (pause) return;
      case (exp_state)
         0: if (mem_ready) exp_state = 1;
         1: begin build_path(opcode); advance(); end
         3, 5: if (mem_ready) advance();
         default: advance();
      endcase
   endtask

   task automatic cycle();
      @(negedge multi_clk);
      check("state", {28'd0, current_state}, exp_state);
      check($sformatf("outs_s%0d", exp_state), {15'd0, got_vec},
            {15'd0, exp_out(exp_state, opcode, zero, mem_ready, pause)});
      obs_done = instr_done;
      obs_ill = illegal_op;
      step_model();
      @(posedge multi_clk);
      #1;
   endtask

   task automatic run_to(input int target, input string tag);
      int n = 0;
      while (exp_state != target && n < 30) begin
         cycle();
         n++;
      end
      check(tag, {28'd0, current_state}, target);
   endtask

   task automatic run_lat(input logic [5:0] op, input int exp_lat,
                          input string tag);
      int n = 0;
      opcode = op; mem_ready = 1; pause = 0;
      do begin
         cycle();
         n++;
      end while (!obs_done && n < 20);
      check(tag, n, exp_lat);
   endtask

   initial begin
      logic [5:0] ops [10];
      ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h02,
              6'h08, 6'h0A, 6'h0C, 6'h0D};

      // reset asserted asynchronously while strobes would otherwise fire
      #1 rst_n = 0;
      #1;
      check("rst_async_state", {28'd0, current_state}, 15);
      repeat (3) begin
         @(negedge multi_clk);
         check("rst_state", {28'd0, current_state}, 15);
         check("rst_outs", {15'd0, got_vec}, 0);
         check("rst13_state", {28'd0, st13}, 13);
         check("rst13_outs", {15'd0, got13}, 0);
      end
      #1 rst_n = 1;
      #1;
      check("boot_idle", {28'd0, current_state}, 15);
      @(posedge multi_clk);
      #1;
      check("boot13_to_if", {28'd0, st13}, 0);
      exp_state = 0;

      zero = 1;
      run_lat(6'h23, 5, "lat_lw");
      run_lat(6'h2B, 4, "lat_sw");
      run_lat(6'h00, 4, "lat_r");
      run_lat(6'h0C, 4, "lat_i");
      run_lat(6'h04, 3, "lat_beq");
      run_lat(6'h05, 3, "lat_bne");
      run_lat(6'h02, 3, "lat_j");

      // illegal opcode
      opcode = 6'h3F;
      run_to(1, "ill_reach_id");
      cycle();
      check("ill_pulse", {31'd0, obs_ill}, 1);
      check("ill_next_if", {28'd0, current_state}, 0);

      // sw with memory wait
      opcode = 6'h2B;
      run_to(5, "sw_reach_wr");
      mem_ready = 0;
      cycle();
      cycle();
      check("sw_hold", {28'd0, current_state}, 5);
      mem_ready = 1;
      cycle();
      check("sw_done", {31'd0, obs_done}, 1);

      // pause in EXE_R
      opcode = 6'h00;
      run_to(6, "r_reach_exe");
      pause = 1;
      repeat (4) cycle();
      check("pause_hold", {28'd0, current_state}, 6);
      pause = 0;
      run_to(7, "r_reach_wb");

      // reset mid-instruction
      #2 rst_n = 0;
      #1;
      check("midrst_state", {28'd0, current_state}, 15);
      check("midrst_regw", {31'd0, reg_write}, 0);
      @(negedge multi_clk);
      check("midrst_outs", {15'd0, got_vec}, 0);
      #1 rst_n = 1;
      @(posedge multi_clk);
      #1;
      q.delete();
      exp_state = 0;

      // random traffic
      for (int i = 0; i < 600; i++) begin
         if (exp_state == 0) begin
            if ($urandom_range(0, 7) == 0)
               opcode = 6'($urandom_range(0, 63));
            else
               opcode = ops[$urandom_range(0, 9)];
         end
         mem_ready = ($urandom_range(0, 3) != 0);
         pause = ($urandom_range(0, 7) == 0);
         zero = 1'($urandom_range(0, 1));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
